branch_pc_unit: RTL and testbench

Program-counter and branch-resolution stage sitting directly downstream of the equality `comparator`. It issues sequential instruction addresses and, on a branch request, drives the comparator's `En` and samples its `out` one cycle later. Depending on that result it either resumes at PC+1 or redirects to the branch target with a one-cycle flush bubble. An optional link register captures the return address of taken linking branches.

---
 rtl/branch_pc_unit.sv | 118 +++++++++++
 tb/tb_branch_pc_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution stage downstream of the equality comparator.
// Define BRANCH_PC_LINK_EN to add the link register and the link_addr port.
module branch_pc_unit #(
   parameter int unsigned           width     = 8,
   parameter logic [width-1:0]      RESET_VEC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             En,
   input  logic             br_req,
   input  logic             br_link,
   input  logic [width-1:0] br_target,
   input  logic             cmp_out,
   output logic             cmp_en,
   output logic [width-1:0] pc,
   output logic             pc_valid,
   output logic             busy,
`ifdef BRANCH_PC_LINK_EN
   output logic             flush,
   output logic [width-1:0] link_addr
`else
   output logic             flush
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      RESOLVE  = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [width-1:0] pc_q, pc_d;
   logic [width-1:0] tgt_q, tgt_d;
   logic [width-1:0] ret_q, ret_d;
   logic             capture;

   // Next state and next pc; everything holds whenever En is low.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      ret_d   = ret_q;
      capture = 1'b0;
      if (En) begin
         case (state_q)
            IDLE: begin
               pc_d    = RESET_VEC;
               state_d = FETCH;
            end
            FETCH: begin
               if (br_req) begin
                  tgt_d   = br_target;
                  ret_d   = pc_q + 1'b1;
                  capture = 1'b1;
                  state_d = RESOLVE;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
            RESOLVE: begin
               if (cmp_out) begin
                  pc_d    = tgt_q;
                  state_d = REDIRECT;
               end else begin
                  pc_d    = ret_q;
                  state_d = FETCH;
               end
            end
            REDIRECT: state_d = FETCH;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_VEC;
         tgt_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         ret_q   <= ret_d;
      end
   end

`ifdef BRANCH_PC_LINK_EN
   logic             link_q;
   logic [width-1:0] link_addr_q;

   // The return address is published on the edge that leaves RESOLVE as taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         link_q      <= 1'b0;
         link_addr_q <= '0;
      end else begin
         if (capture) link_q <= br_link;
         if (En && state_q == RESOLVE && cmp_out && link_q) link_addr_q <= ret_q;
      end
   end

   assign link_addr = link_addr_q;
`else
   logic unused_link;
   assign unused_link = br_link & capture;
`endif

   assign pc       = pc_q;
   assign pc_valid = (state_q == FETCH);
   assign cmp_en   = (state_q == RESOLVE);
   assign busy     = (state_q == RESOLVE) || (state_q == REDIRECT);
   assign flush    = (state_q == REDIRECT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a driver queues per-cycle expectations, a monitor
// pops and compares them on the falling edge.
module tb_branch_pc_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       En = 1'b0;
   logic       br_req = 1'b0;
   logic       br_link = 1'b0;
   logic [7:0] br_target = 8'h00;
   logic       cmp_out = 1'b0;
   logic       cmp_en;
   logic [7:0] pc;
   logic       pc_valid;
   logic       busy;
   logic       flush;
   logic [7:0] link_act;

   int checks = 0;
   int failures = 0;
   int step_no = 0;

   // Expected word: {pc, pc_valid, cmp_en, busy, flush, link_addr}
   logic [19:0] exp_q[$];

   always #5 clk = ~clk;

`ifdef BRANCH_PC_LINK_EN
   logic [7:0] link_addr;
   assign link_act = link_addr;
   branch_pc_unit #(.width(8), .RESET_VEC(8'h10)) dut (
      .clk(clk), .rst(rst), .En(En), .br_req(br_req), .br_link(br_link),
      .br_target(br_target), .cmp_out(cmp_out), .cmp_en(cmp_en), .pc(pc),
      .pc_valid(pc_valid), .busy(busy), .flush(flush), .link_addr(link_addr)
   );
   function automatic logic [7:0] lk(input logic [7:0] v);
      return v;
   endfunction
`else
   assign link_act = 8'h00;
   branch_pc_unit #(.width(8), .RESET_VEC(8'h10)) dut (
      .clk(clk), .rst(rst), .En(En), .br_req(br_req), .br_link(br_link),
      .br_target(br_target), .cmp_out(cmp_out), .cmp_en(cmp_en), .pc(pc),
      .pc_valid(pc_valid), .busy(busy), .flush(flush)
   );
   function automatic logic [7:0] lk(input logic [7:0] v);
      return (v == 8'hxx) ? 8'h00 : 8'h00;
   endfunction
`endif

   // Expectation describes the outputs during this cycle; the inputs act on the next edge.
   task automatic step(input logic [7:0] e_pc, input logic e_pv, input logic e_ce,
                       input logic e_busy, input logic e_flush, input logic [7:0] e_link,
                       input logic i_rst, input logic i_en, input logic i_br,
                       input logic i_link, input logic [7:0] i_tgt, input logic i_cmp);
      @(posedge clk);
      #1;
      exp_q.push_back({e_pc, e_pv, e_ce, e_busy, e_flush, e_link});
      rst       = i_rst;
      En        = i_en;
      br_req    = i_br;
      br_link   = i_link;
      br_target = i_tgt;
      cmp_out   = i_cmp;
   endtask

   always @(negedge clk) begin
      logic [19:0] e;
      logic [19:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pc, pc_valid, cmp_en, busy, flush, link_act};
         step_no++;
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL cycle%0d pc/pv/ce/busy/flush/link actual=%h %b%b%b%b %h required=%h %b%b%b%b %h",
                     step_no, a[19:12], a[11], a[10], a[9], a[8], a[7:0],
                     e[19:12], e[11], e[10], e[9], e[8], e[7:0]);
         end
      end
   end

   initial begin
      //     exp: pc    pv ce bz fl link         in: rst en br lk tgt    cmp
      step(8'h10, 0, 0, 0, 0, 8'h00,  1, 0, 0, 0, 8'h00, 0);  // reset state
      step(8'h10, 0, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h10, 1, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);  // first fetch at RESET_VEC
      step(8'h11, 1, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h12, 1, 0, 0, 0, 8'h00,  0, 1, 1, 0, 8'hFE, 0);  // taken branch to 0xFE
      step(8'h12, 0, 1, 1, 0, 8'h00,  0, 1, 0, 0, 8'h00, 1);
      step(8'hFE, 0, 0, 1, 1, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'hFE, 1, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'hFF, 1, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h00, 1, 0, 0, 0, 8'h00,  0, 1, 1, 0, 8'h20, 0);  // wrapped; branch to 0x20
      step(8'h00, 0, 1, 1, 0, 8'h00,  0, 1, 0, 0, 8'h00, 1);
      step(8'h20, 0, 0, 1, 1, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h20, 1, 0, 0, 0, 8'h00,  0, 1, 1, 1, 8'h80, 0);  // linking, not taken
      step(8'h20, 0, 1, 1, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h21, 1, 0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);  // stall in FETCH
      step(8'h21, 1, 0, 0, 0, 8'h00,  0, 1, 1, 1, 8'h80, 0);  // taken linking branch
      step(8'h21, 0, 1, 1, 0, 8'h00,  0, 0, 1, 0, 8'h33, 1);  // stall; stray request ignored
      step(8'h21, 0, 1, 1, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
      step(8'h21, 0, 1, 1, 0, 8'h00,  0, 0, 0, 0, 8'h00, 0);
      step(8'h21, 0, 1, 1, 0, 8'h00,  0, 1, 0, 0, 8'h00, 1);
      step(8'h80, 0, 0, 1, 1, lk(8'h22),  0, 1, 1, 0, 8'h44, 0);  // request in REDIRECT ignored
      step(8'h80, 1, 0, 0, 0, lk(8'h22),  0, 1, 1, 0, 8'h55, 0);
      step(8'h80, 0, 1, 1, 0, lk(8'h22),  0, 1, 0, 0, 8'h00, 1);
      step(8'h55, 0, 0, 1, 1, lk(8'h22),  1, 1, 0, 0, 8'h00, 0);  // reset during REDIRECT
      step(8'h10, 0, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h10, 1, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      step(8'h11, 1, 0, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0);
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
